// File: rtl/move_stream_serializer_pkg.sv
// Shared definitions for the move stream serializer: state encoding,
// default slot width and the move-count width helper.
package move_stream_serializer_pkg;

  localparam int DEFAULT_SLOT_W = 4;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_SEND = 1'b1;

  typedef enum logic [0:0] {
    S_IDLE = ST_IDLE,
    S_SEND = ST_SEND
  } state_e;

  // Wide enough to hold the all-slots-non-zero total without wrapping.
  function automatic int count_width(input int slots_per_beat, input int num_beats);
    return $clog2(slots_per_beat * num_beats + 1);
  endfunction

endpackage

// File: rtl/move_stream_serializer_if.sv
// Load/beat handshake bundle between move generator, serializer and consumer.
// The serializer connects through the slave modport.
interface move_stream_serializer_if
  import move_stream_serializer_pkg::*;
#(
  parameter int SLOT_W         = DEFAULT_SLOT_W,
  parameter int SLOTS_PER_BEAT = 4,
  parameter int NUM_BEATS      = 2
) ();

  logic                                          in_valid;
  logic                                          in_ready;
  logic [SLOT_W*SLOTS_PER_BEAT*NUM_BEATS-1:0]    in_word;
  logic                                          out_valid;
  logic                                          out_ready;
  logic [SLOT_W*SLOTS_PER_BEAT-1:0]              out_slots;
  logic                                          out_last;
  logic [count_width(SLOTS_PER_BEAT, NUM_BEATS)-1:0] move_count;
  logic                                          done;

  modport master (
    output in_valid, in_word, out_ready,
    input  in_ready, out_valid, out_slots, out_last, move_count, done
  );

  modport slave (
    input  in_valid, in_word, out_ready,
    output in_ready, out_valid, out_slots, out_last, move_count, done
  );

endinterface

// File: rtl/move_stream_serializer_slot_nonzero_counter.sv
// Combinational population count of non-zero slots within one beat.
module slot_nonzero_counter #(
  parameter int SLOT_W         = 4,
  parameter int SLOTS_PER_BEAT = 4
) (
  input  logic [SLOT_W*SLOTS_PER_BEAT-1:0]        beat,
  output logic [$clog2(SLOTS_PER_BEAT+1)-1:0]     count
);

  localparam int CW = $clog2(SLOTS_PER_BEAT + 1);

  // Tally slots holding a move
  always_comb begin
    count = '0;
    for (int i = 0; i < SLOTS_PER_BEAT; i++) begin
      if (|beat[i*SLOT_W +: SLOT_W]) begin
        count = count + CW'(1);
      end else begin
        count = count;
      end
    end
  end

endmodule

// File: rtl/move_stream_serializer.sv
// Serializes a packed word of move slots into beats (MS beat first) and reports
// the non-zero slot total. Optional SERIALIZER_SKIP_EMPTY_EN suppresses all-zero beats.
module move_stream_serializer
  import move_stream_serializer_pkg::*;
#(
  parameter int SLOT_W         = DEFAULT_SLOT_W,
  parameter int SLOTS_PER_BEAT = 4,
  parameter int NUM_BEATS      = 2
) (
  input logic                     clk,
  input logic                     rst,
  move_stream_serializer_if.slave bus
);

  localparam int BEAT_W  = SLOT_W * SLOTS_PER_BEAT;
  localparam int WORD_W  = BEAT_W * NUM_BEATS;
  localparam int CNT_W   = count_width(SLOTS_PER_BEAT, NUM_BEATS);
  localparam int BCNT_W  = $clog2(SLOTS_PER_BEAT + 1);
  localparam int IDX_W   = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BEATS - 1);

  state_e              state_r, state_n;
  logic [WORD_W-1:0]   shift_r, shift_n;
  logic [IDX_W-1:0]    idx_r, idx_n;
  logic [CNT_W-1:0]    count_r, count_n;
  logic [CNT_W-1:0]    move_count_r, move_count_n;
  logic                done_r, done_n;

  logic [BEAT_W-1:0]   beat_s;
  logic [BCNT_W-1:0]   beat_cnt_s;
  logic                skip_s;
  logic                last_s;
  logic                out_valid_s;
  logic                advance_s;

  assign beat_s = shift_r[WORD_W-1 -: BEAT_W];

  slot_nonzero_counter #(
    .SLOT_W         (SLOT_W),
    .SLOTS_PER_BEAT (SLOTS_PER_BEAT)
  ) u_counter (
    .beat  (beat_s),
    .count (beat_cnt_s)
  );

`ifdef SERIALIZER_SKIP_EMPTY_EN
  // Per-beat non-zero flags, MSB tracks the beat currently at the top of shift_r.
  logic [NUM_BEATS-1:0] mask_r, mask_n, load_mask_s;

  // Flag which beats of the incoming word carry any move
  always_comb begin
    load_mask_s = '0;
    for (int b = 0; b < NUM_BEATS; b++) begin
      load_mask_s[NUM_BEATS-1-b] = |bus.in_word[WORD_W-1-b*BEAT_W -: BEAT_W];
    end
  end

  assign skip_s = (state_r == S_SEND) && !mask_r[NUM_BEATS-1];
  assign last_s = ((mask_r << 1) == '0);
`else
  assign skip_s = 1'b0;
  assign last_s = (idx_r == LAST_IDX);
`endif

  assign out_valid_s = (state_r == S_SEND) && !skip_s;
  assign advance_s   = (out_valid_s && bus.out_ready) || skip_s;

  assign bus.in_ready   = (state_r == S_IDLE);
  assign bus.out_valid  = out_valid_s;
  assign bus.out_slots  = beat_s;
  assign bus.out_last   = out_valid_s && last_s;
  assign bus.move_count = move_count_r;
  assign bus.done       = done_r;

  // Next-state, shift and count update
  always_comb begin
    state_n      = state_r;
    shift_n      = shift_r;
    idx_n        = idx_r;
    count_n      = count_r;
    move_count_n = move_count_r;
    done_n       = 1'b0;
`ifdef SERIALIZER_SKIP_EMPTY_EN
    mask_n       = mask_r;
`endif
    case (state_r)
      S_IDLE: begin
        if (bus.in_valid) begin
          shift_n = bus.in_word;
          idx_n   = '0;
          count_n = '0;
          state_n = S_SEND;
`ifdef SERIALIZER_SKIP_EMPTY_EN
          mask_n  = load_mask_s;
`endif
        end else begin
          state_n = S_IDLE;
        end
      end
      S_SEND: begin
        if (advance_s) begin
          shift_n = shift_r << BEAT_W;
          idx_n   = idx_r + IDX_W'(1);
          count_n = count_r + CNT_W'(beat_cnt_s);
`ifdef SERIALIZER_SKIP_EMPTY_EN
          mask_n  = mask_r << 1;
`endif
          if (idx_r == LAST_IDX) begin
            state_n      = S_IDLE;
            move_count_n = count_n;
            done_n       = 1'b1;
          end else begin
            state_n = S_SEND;
          end
        end else begin
          state_n = S_SEND;
        end
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= S_IDLE;
      shift_r      <= '0;
      idx_r        <= '0;
      count_r      <= '0;
      move_count_r <= '0;
      done_r       <= 1'b0;
`ifdef SERIALIZER_SKIP_EMPTY_EN
      mask_r       <= '0;
`endif
    end else begin
      state_r      <= state_n;
      shift_r      <= shift_n;
      idx_r        <= idx_n;
      count_r      <= count_n;
      move_count_r <= move_count_n;
      done_r       <= done_n;
`ifdef SERIALIZER_SKIP_EMPTY_EN
      mask_r       <= mask_n;
`endif
    end
  end

endmodule
